dmem_controller: RTL

DMEM_CONTROLLER -- requirements
Module: dmem_controller

---
 rtl/dmem_pkg.sv | 23 ++
 rtl/dmem_load_align.sv | 47 ++++
 rtl/dmem_controller.sv | 125 ++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg -- shared encodings for the data-memory controller.
//   size_e  : access size encodings (byte/half/word/double)
//   state_e : response-stage occupancy
//   size_bytes() : number of bytes touched by an access of a given size
package dmem_pkg;

   typedef enum logic [1:0] {
      SZ_B = 2'd0,
      SZ_H = 2'd1,
      SZ_W = 2'd2,
      SZ_D = 2'd3
   } size_e;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_e;

   function automatic int unsigned size_bytes(input logic [1:0] sz);
      return 32'd1 << sz;
   endfunction

endpackage

// File: rtl/dmem_load_align.sv
// dmem_load_align -- gathers the bytes of a load from the storage image and
// sign/zero-extends them to XLEN.
//   mem         : whole byte storage image
//   base        : byte offset of the first byte (wraps inside the image; only
//                 meaningful for in-range accesses, the caller masks errors)
//   size        : access size (size_e)
//   is_unsigned : zero-extend when 1, sign-extend when 0 (ignored for double)
//   data        : little-endian assembled, extended load value
// XLEN is expected to be 64 (double-word loads fill the full result).
module dmem_load_align
   import dmem_pkg::*;
#(
   parameter int XLEN        = 64,
   parameter int DEPTH_BYTES = 128,
   parameter int AW          = $clog2(DEPTH_BYTES)
) (
   input  logic [DEPTH_BYTES-1:0][7:0] mem,
   input  logic [AW-1:0]               base,
   input  logic [1:0]                  size,
   input  logic                        is_unsigned,
   output logic [XLEN-1:0]             data
);

   localparam int NB = XLEN / 8;

   logic [NB-1:0][7:0] raw;
   logic [XLEN-1:0]    raw_w;
   logic [XLEN-1:0]    mask;
   logic               sign;

   assign raw_w = raw;

   always_comb begin
      for (int k = 0; k < NB; k++) begin
         raw[k] = mem[base + AW'(k)];
      end
      case (size)
         SZ_B:    begin mask = XLEN'(8'hFF);         sign = raw_w[7];  end
         SZ_H:    begin mask = XLEN'(16'hFFFF);      sign = raw_w[15]; end
         SZ_W:    begin mask = XLEN'(32'hFFFF_FFFF); sign = raw_w[31]; end
         default: begin mask = '1;                   sign = raw_w[XLEN-1]; end
      endcase
      // For a full-width access ~mask is zero, so is_unsigned has no effect.
      data = (raw_w & mask) | ((sign & ~is_unsigned) ? ~mask : '0);
   end

endmodule

// File: rtl/dmem_controller.sv
// dmem_controller -- byte-addressable data memory with a one-entry response
// stage. Loads and stores are performed on the accept edge; the response
// appears the following cycle and is held until consumed.
//   clk, rst_n          : clock, asynchronous active-low reset
//   req_valid/req_ready : request handshake
//   req_write           : 1 store, 0 load
//   req_size            : 0 byte, 1 half, 2 word, 3 double
//   req_unsigned        : zero-extend loads when 1
//   req_addr, req_wdata : byte address, little-endian store data
//   rsp_valid/rsp_ready : response handshake
//   rsp_rdata, rsp_err  : load data (0 for stores/errors), fault flag
// Build option: define DMEM_MISALIGN_EN to let in-range misaligned accesses
// complete byte-wise instead of faulting.
module dmem_controller
   import dmem_pkg::*;
#(
   parameter int XLEN        = 64,
   parameter int DEPTH_BYTES = 128
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            req_write,
   input  logic [1:0]      req_size,
   input  logic            req_unsigned,
   input  logic [XLEN-1:0] req_addr,
   input  logic [XLEN-1:0] req_wdata,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic [XLEN-1:0] rsp_rdata,
   output logic            rsp_err
);

   localparam int AW = $clog2(DEPTH_BYTES);
   localparam int NB = XLEN / 8;

   state_e                      state_q, state_d;
   logic [DEPTH_BYTES-1:0][7:0] mem_q, mem_d;
   logic [XLEN-1:0]             rdata_q, rdata_d;
   logic                        err_q, err_d;

   logic                        accept;
   logic [XLEN-1:0]             nbytes;
   logic [XLEN:0]               end_addr;
   logic                        range_err, align_err, acc_err;
   logic [XLEN-1:0]             load_data;

   // Fault checks. end_addr carries one extra bit so addresses near the top
   // of the XLEN space cannot wrap back into range.
   assign nbytes    = XLEN'(size_bytes(req_size));
   assign end_addr  = {1'b0, req_addr} + {1'b0, nbytes};
   assign range_err = end_addr > (XLEN+1)'(DEPTH_BYTES);
`ifdef DMEM_MISALIGN_EN
   assign align_err = 1'b0;
`else
   assign align_err = |(req_addr & (nbytes - XLEN'(1)));
`endif
   assign acc_err   = range_err | align_err;

   assign req_ready = (state_q == ST_EMPTY) | rsp_ready;
   assign accept    = req_valid & req_ready;
   assign rsp_valid = (state_q == ST_FULL);
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;

   // Reads the pre-write image, so data is sampled on the accept edge.
   dmem_load_align #(
      .XLEN        (XLEN),
      .DEPTH_BYTES (DEPTH_BYTES),
      .AW          (AW)
   ) u_load_align (
      .mem         (mem_q),
      .base        (req_addr[AW-1:0]),
      .size        (req_size),
      .is_unsigned (req_unsigned),
      .data        (load_data)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_EMPTY: if (accept)                state_d = ST_FULL;
         ST_FULL:  if (rsp_ready && !accept)  state_d = ST_EMPTY;
         default:                             state_d = ST_EMPTY;
      endcase
   end

   always_comb begin
      rdata_d = rdata_q;
      err_d   = err_q;
      if (accept) begin
         err_d   = acc_err;
         rdata_d = (acc_err | req_write) ? '0 : load_data;
      end
   end

   always_comb begin
      mem_d = mem_q;
      if (accept && req_write && !acc_err) begin
         for (int k = 0; k < NB; k++) begin
            if (32'(k) < size_bytes(req_size)) begin
               mem_d[req_addr[AW-1:0] + AW'(k)] = req_wdata[8*k +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_EMPTY;
         rdata_q <= '0;
         err_q   <= 1'b0;
         for (int i = 0; i < DEPTH_BYTES; i++) begin
            mem_q[i] <= 8'(i + 1);
         end
      end else begin
         state_q <= state_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         mem_q   <= mem_d;
      end
   end

endmodule
